// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered.
module sync_fifo_lvl #(
  parameter int DSIZE      = 8,
  parameter int ASIZE      = 4,
  parameter int AFULL_LVL  = 14,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AFULL_L  = (ASIZE+1)'(AFULL_LVL);
  localparam logic [ASIZE:0] AEMPTY_L = (ASIZE+1)'(AEMPTY_LVL);

  logic [DSIZE-1:0] mem [DEPTH];

  logic [ASIZE:0]   wptr_q, wptr_d;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic [ASIZE:0]   level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [ASIZE-1:0] waddr, raddr;
  logic             wr_acc, rd_acc;

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // Full when only the wrap bits differ; empty when the pointers match exactly.
  assign wfull  = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (waddr == raddr);
  assign rempty = (wptr_q == rptr_q);

  assign almost_full  = (level_q >= AFULL_L);
  assign almost_empty = (level_q <= AEMPTY_L);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = winc && !wfull;
  assign rd_acc = rinc && !rempty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wptr_d = wptr_q + 1'b1;
    if (rd_acc) rptr_d = rptr_q + 1'b1;

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A rejected request in the same cycle as err_clr keeps the flag set.
    if (winc && wfull)  overflow_d = 1'b1;
    else if (err_clr)   overflow_d = 1'b0;

    if (rinc && rempty) underflow_d = 1'b1;
    else if (err_clr)   underflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; gating on rst stops writes while reset is held.
  always_ff @(posedge clk) begin
    if (wr_acc && rst) mem[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  logic [DSIZE-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl: directed scenarios plus random traffic
// compared against a queue-based occupancy model.
module tb_sync_fifo_lvl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wdata;
  logic       winc, rinc, err_clr;
  logic [7:0] rdata;
  logic       wfull, rempty, almost_full, almost_empty;
  logic [4:0] level;
  logic       overflow, underflow;

  int nVec  = 0;
  int nFail = 0;

  logic [7:0] mq [$];
  logic       mOv, mUn;
  logic [7:0] mRdata;

  sync_fifo_lvl #(.DSIZE(8), .ASIZE(4), .AFULL_LVL(14), .AEMPTY_LVL(2)) dut (
    .clk(clk), .rst(rst), .wdata(wdata), .winc(winc), .rinc(rinc), .err_clr(err_clr),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .almost_full(almost_full),
    .almost_empty(almost_empty), .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOv    = 1'b0;
    mUn    = 1'b0;
    mRdata = 8'h00;
  endtask

  // Occupancy-level model: flags are judged on the pre-edge queue size.
  task automatic modelStep(input logic w, input logic r, input logic [7:0] d, input logic clr);
    bit full, empty;
    full  = (mq.size() == 16);
    empty = (mq.size() == 0);
    if (w && full)   mOv = 1'b1;
    else if (clr)    mOv = 1'b0;
    if (r && empty)  mUn = 1'b1;
    else if (clr)    mUn = 1'b0;
    if (r && !empty) mRdata = mq.pop_front();
    if (w && !full)  mq.push_back(d);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".level"},        32'(level),        32'(mq.size()));
    check({tag, ".wfull"},        32'(wfull),        32'(mq.size() == 16));
    check({tag, ".rempty"},       32'(rempty),       32'(mq.size() == 0));
    check({tag, ".almost_full"},  32'(almost_full),  32'(mq.size() >= 14));
    check({tag, ".almost_empty"}, 32'(almost_empty), 32'(mq.size() <= 2));
    check({tag, ".overflow"},     32'(overflow),     32'(mOv));
    check({tag, ".underflow"},    32'(underflow),    32'(mUn));
`ifdef SYNC_FIFO_FWFT_EN
    if (mq.size() != 0) check({tag, ".rdata"}, 32'(rdata), 32'(mq[0]));
`else
    check({tag, ".rdata"}, 32'(rdata), 32'(mRdata));
`endif
  endtask

  task automatic applyStimulus(input string tag, input logic w, input logic r,
                               input logic [7:0] d, input logic clr);
    winc    = w;
    rinc    = r;
    wdata   = d;
    err_clr = clr;
    @(posedge clk);
    modelStep(w, r, d, clr);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [7:0] wseq;
    rst = 1'b0; winc = 1'b0; rinc = 1'b0; err_clr = 1'b0; wdata = 8'h00;
    modelReset();
    @(posedge clk); #1;
    checkOutput("reset");
    rst = 1'b1;

    // Fill from empty; thresholds are observed on every cycle.
    for (int i = 0; i < 16; i++) applyStimulus("fill", 1'b1, 1'b0, 8'(i), 1'b0);

    applyStimulus("ovf_write", 1'b1, 1'b0, 8'hAA, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus("drain", 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Full with simultaneous write and read: write dropped, read taken.
    for (int i = 0; i < 16; i++) applyStimulus("refill", 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
    applyStimulus("full_wr_rd", 1'b1, 1'b1, 8'hEE, 1'b0);
    applyStimulus("full_clr", 1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++) applyStimulus("drain2", 1'b0, 1'b1, 8'h00, 1'b0);

    // Steady streaming at level 5 wraps the pointers twice.
    for (int i = 0; i < 5; i++) applyStimulus("pre5", 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus("stream", 1'b1, 1'b1, 8'(8'h90 + i), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus("post5", 1'b0, 1'b1, 8'h00, 1'b0);

    applyStimulus("unf_read", 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus("empty_wr_rd", 1'b1, 1'b1, 8'h33, 1'b0);
    applyStimulus("pop33", 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus("unf_set_wins", 1'b0, 1'b1, 8'h00, 1'b1);
    applyStimulus("unf_clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 7; i++) applyStimulus("pre_rst", 1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    applyStimulus("pre_rst_ovf", 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus("pre_rst_w", 1'b1, 1'b0, 8'hC7, 1'b0);
    winc = 1'b1; wdata = 8'hD0;
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst");
    @(posedge clk); #1;
    checkOutput("rst_held");
    rst = 1'b1;
    applyStimulus("post_rst_w", 1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus("post_rst_r", 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus("fwft_w", 1'b1, 1'b0, 8'h5A, 1'b0);
    applyStimulus("fwft_idle", 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus("fwft_r", 1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus("fwft_after", 1'b0, 1'b0, 8'h00, 1'b0);

    // Random traffic alternating write-heavy and read-heavy phases.
    for (int i = 0; i < 400; i++) begin
      int wBias;
      wBias = ((i / 50) % 2 == 0) ? 80 : 25;
      wseq  = 8'($urandom);
      applyStimulus("rand",
                    ($urandom_range(99) < wBias),
                    ($urandom_range(99) < (105 - wBias)),
                    wseq,
                    ($urandom_range(99) < 8));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
